// File: rtl/sram_axi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_axi_bridge_pkg
// Shared definitions for the SRAM-to-AXI3 bridge:
//   - bridge_state_t : FSM state encoding (3 bits)
//   - AXI size / burst constants used on the address channels
//   - default transaction IDs for fetches and data accesses
//   - size_for_bytes : maps an enabled-byte count onto an AXI size code
// -----------------------------------------------------------------------------
package sram_axi_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_D_RADDR = 3'd1,
      ST_D_RDATA = 3'd2,
      ST_D_WADDR = 3'd3,
      ST_D_WRESP = 3'd4,
      ST_I_RADDR = 3'd5,
      ST_I_RDATA = 3'd6
   } bridge_state_t;

   localparam logic [2:0] AXI_SIZE_1B    = 3'd0;
   localparam logic [2:0] AXI_SIZE_2B    = 3'd1;
   localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [3:0] INST_ID_DEF = 4'd0;
   localparam logic [3:0] DATA_ID_DEF = 4'd1;

   // One enabled byte -> byte access, two -> halfword, anything else -> word.
   function automatic logic [2:0] size_for_bytes(input logic [3:0] nbytes);
      case (nbytes)
         4'd1:    size_for_bytes = AXI_SIZE_1B;
         4'd2:    size_for_bytes = AXI_SIZE_2B;
         default: size_for_bytes = AXI_SIZE_4B;
      endcase
   endfunction

endpackage

// File: rtl/sram_axi_bridge_axi_wchan_join.sv
// -----------------------------------------------------------------------------
// axi_wchan_join
// Raises awvalid and wvalid together while 'active' is high and tracks the two
// handshakes independently. Each valid drops once its own handshake has been
// seen; both_done pulses in the cycle the second (or a simultaneous) handshake
// completes, which also re-arms the tracker for the next write.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   active          bridge is in its write-address phase
//   awready, wready AXI slave readies
//   awvalid, wvalid AXI valids
//   both_done       both channels have handshaken (combinational)
// -----------------------------------------------------------------------------
module axi_wchan_join (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic awready,
   input  logic wready,
   output logic awvalid,
   output logic wvalid,
   output logic both_done
);

   logic aw_done_reg;
   logic w_done_reg;
   logic aw_hs;
   logic w_hs;

   assign awvalid   = active & ~aw_done_reg;
   assign wvalid    = active & ~w_done_reg;
   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   assign both_done = active & (aw_done_reg | aw_hs) & (w_done_reg | w_hs);

   always_ff @(posedge clk) begin
      if (rst || both_done) begin
         aw_done_reg <= 1'b0;
         w_done_reg  <= 1'b0;
      end else begin
         if (aw_hs) aw_done_reg <= 1'b1;
         if (w_hs)  w_done_reg  <= 1'b1;
      end
   end

endmodule

// File: rtl/sram_axi_bridge.sv
// -----------------------------------------------------------------------------
// sram_axi_bridge
// Converts the core's inst-SRAM and data-SRAM request ports into single-beat
// AXI3 transactions, one outstanding at a time, data before fetch.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_sram_*                   fetch request / returned instruction
//   data_sram_*                   load/store request / returned load data
//   stallreq_bus                  high while any requested access is pending
//   ar*/r*                        AXI read address / read data channels
//   aw*/w*/b*                     AXI write address / data / response channels
//   *len/*burst/*lock/*cache/*prot constant tie-offs (single INCR beat)
// -----------------------------------------------------------------------------
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
#(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter logic [3:0]  INST_ID = INST_ID_DEF,
   parameter logic [3:0]  DATA_ID = DATA_ID_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   // core side
   input  logic                  inst_sram_en,
   input  logic [ADDR_W-1:0]     inst_sram_addr,
   output logic [DATA_W-1:0]     inst_sram_rdata,
   input  logic                  data_sram_en,
   input  logic [DATA_W/8-1:0]   data_sram_wen,
   input  logic [ADDR_W-1:0]     data_sram_addr,
   input  logic [DATA_W-1:0]     data_sram_wdata,
   output logic [DATA_W-1:0]     data_sram_rdata,
   output logic                  stallreq_bus,
   // AXI read address
   output logic [3:0]            arid,
   output logic [ADDR_W-1:0]     araddr,
   output logic [3:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [1:0]            arlock,
   output logic [3:0]            arcache,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   // AXI read data
   input  logic [3:0]            rid,
   input  logic [DATA_W-1:0]     rdata,
   input  logic                  rvalid,
   output logic                  rready,
   // AXI write address
   output logic [3:0]            awid,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [3:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [1:0]            awlock,
   output logic [3:0]            awcache,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   // AXI write data
   output logic [3:0]            wid,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   // AXI write response
   input  logic                  bvalid,
   output logic                  bready
);

   localparam int STRB_W = DATA_W / 8;

   bridge_state_t         state_reg, state_next;
   logic [ADDR_W-1:0]     addr_reg;
   logic [DATA_W-1:0]     wdata_reg;
   logic [STRB_W-1:0]     wen_reg;
   logic                  inst_done_reg;
   logic                  data_done_reg;
   logic [DATA_W-1:0]     inst_rdata_reg;
   logic [DATA_W-1:0]     data_rdata_reg;

   logic                  inst_req;
   logic                  data_req;
   logic                  inst_fin;
   logic                  data_rfin;
   logic                  data_wfin;
   logic                  wr_active;
   logic                  wr_both_done;
   logic [3:0]            wen_cnt;

   // ---------------------------------------------------------------- core side
   assign inst_req     = inst_sram_en & ~inst_done_reg;
   assign data_req     = data_sram_en & ~data_done_reg;
   assign stallreq_bus = inst_req | data_req;

   assign inst_sram_rdata = inst_rdata_reg;
   assign data_sram_rdata = data_rdata_reg;

   // A beat whose ID does not match the outstanding request is ignored.
   assign inst_fin  = (state_reg == ST_I_RDATA) & rvalid & (rid == INST_ID);
   assign data_rfin = (state_reg == ST_D_RDATA) & rvalid & (rid == DATA_ID);
   assign data_wfin = (state_reg == ST_D_WRESP) & bvalid;

   // ---------------------------------------------------------------- AXI payload
   // The request is latched when leaving IDLE so the AXI payload stays stable
   // until its handshake even if the core drops en mid-transaction.
   assign araddr = addr_reg;
   assign awaddr = addr_reg;
   assign awid   = DATA_ID;
   assign wid    = DATA_ID;
   assign wdata  = wdata_reg;
   assign wstrb  = wen_reg;
   assign wlast  = 1'b1;
   assign arsize = AXI_SIZE_4B;

   always_comb begin
      wen_cnt = '0;
      for (int i = 0; i < STRB_W; i++) begin
         wen_cnt = wen_cnt + {3'b000, wen_reg[i]};
      end
   end

   assign awsize = size_for_bytes(wen_cnt);

   assign arlen   = 4'd0;
   assign arburst = AXI_BURST_INCR;
   assign arlock  = 2'd0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign awlen   = 4'd0;
   assign awburst = AXI_BURST_INCR;
   assign awlock  = 2'd0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   // ---------------------------------------------------------------- write join
   axi_wchan_join u_wjoin (
      .clk       (clk),
      .rst       (rst),
      .active    (wr_active),
      .awready   (awready),
      .wready    (wready),
      .awvalid   (awvalid),
      .wvalid    (wvalid),
      .both_done (wr_both_done)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      arvalid    = 1'b0;
      arid       = INST_ID;
      rready     = 1'b0;
      bready     = 1'b0;
      wr_active  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (data_req) begin
               state_next = (|data_sram_wen) ? ST_D_WADDR : ST_D_RADDR;
            end else if (inst_req) begin
               state_next = ST_I_RADDR;
            end
         end
         ST_D_RADDR: begin
            arvalid = 1'b1;
            arid    = DATA_ID;
            if (arready) state_next = ST_D_RDATA;
         end
         ST_D_RDATA: begin
            rready = 1'b1;
            if (data_rfin) state_next = ST_IDLE;
         end
         ST_D_WADDR: begin
            wr_active = 1'b1;
            if (wr_both_done) state_next = ST_D_WRESP;
         end
         ST_D_WRESP: begin
            bready = 1'b1;
            if (bvalid) state_next = ST_IDLE;
         end
         ST_I_RADDR: begin
            arvalid = 1'b1;
            arid    = INST_ID;
            if (arready) state_next = ST_I_RDATA;
         end
         ST_I_RDATA: begin
            rready = 1'b1;
            if (inst_fin) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wen_reg        <= '0;
         inst_done_reg  <= 1'b0;
         data_done_reg  <= 1'b0;
         inst_rdata_reg <= '0;
         data_rdata_reg <= '0;
      end else begin
         if (state_reg == ST_IDLE) begin
            if (data_req) begin
               addr_reg  <= data_sram_addr;
               wdata_reg <= data_sram_wdata;
               wen_reg   <= data_sram_wen;
            end else if (inst_req) begin
               addr_reg  <= inst_sram_addr;
            end
         end

         if (inst_fin)  inst_rdata_reg <= rdata;
         if (data_rfin) data_rdata_reg <= rdata;

         // Flags clear in the cycle the core advances. A completion seen while
         // no request is pending (en dropped) must not mark a later one done.
         if (!stallreq_bus) begin
            inst_done_reg <= 1'b0;
            data_done_reg <= 1'b0;
         end else begin
            if (inst_fin)               inst_done_reg <= 1'b1;
            if (data_rfin || data_wfin) data_done_reg <= 1'b1;
         end
      end
   end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the pipeline core and consumes its inst-SRAM and data-SRAM request ports.
- Turns each core access into a single-beat AXI3 transaction (one outstanding at a time).
- Returns the read data and drives a stall request back into the core's stall control until every access in the current cycle has completed.
- Data access has priority over instruction fetch.

Parameters:
- ADDR_W, 32, address width on the core side and the AXI side.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- INST_ID, 4'd0, arid used for instruction fetches.
- DATA_ID, 4'd1, arid/awid used for data accesses.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_sram_en  in  1  fetch request
- inst_sram_addr  in  32  fetch address
- inst_sram_rdata  out  32  fetched instruction
- data_sram_en  in  1  data access request
- data_sram_wen  in  4  byte write enables; 0 means load
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  load data
- stallreq_bus  out  1  asserted while any requested access is incomplete
- arid/araddr/arsize/arvalid  out  4/32/3/1  AXI read address channel
- arready  in  1  AXI read address accept
- rid/rdata/rvalid  in  4/32/1  AXI read data channel
- rready  out  1  AXI read data accept
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AXI write address channel
- awready  in  1  AXI write address accept
- wdata/wstrb/wvalid/wlast  out  32/4/1/1  AXI write data channel
- wready  in  1  AXI write data accept
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response accept
- Tie-offs: all len fields 0, burst INCR, lock/cache/prot 0.

Behaviour:
- Reset, synchronous active-high: state IDLE; all valid/ready outputs 0; rdata registers 0; done flags 0.
- Core contract: the core holds en/addr/wen/wdata stable while stallreq_bus=1.
- stallreq_bus is combinational: (inst_sram_en & ~inst_done) | (data_sram_en & ~data_done).
- Done flags and rdata:
  - inst_done and data_done set on completion of the respective transaction.
  - Both flags clear in the first cycle where stallreq_bus=0, i.e. the core advances.
  - *_rdata registers hold their value until overwritten by the next completion.
- FSM states: IDLE, D_RADDR, D_RDATA, D_WADDR, D_WRESP, I_RADDR, I_RDATA.
- IDLE:
  - If data_sram_en & ~data_done: go to D_WADDR when wen≠0, else D_RADDR.
  - Else if inst_sram_en & ~inst_done: go to I_RADDR.
  - Else stay in IDLE.
- D_RADDR / I_RADDR:
  - arvalid=1 with the ID and address of the request; arsize=2.
  - Advance to *_RDATA when arready=1.
- D_RDATA / I_RDATA:
  - rready=1.
  - On rvalid & rid matching: capture rdata, set the done flag, return to IDLE.
- D_WADDR:
  - awvalid and wvalid raised together; wlast=1; wstrb=wen.
  - awsize = 0 for single-byte wen, 1 for two-byte wen, 2 otherwise.
  - Each valid drops independently once its ready has been seen; both channels must handshake before moving to D_WRESP.
  - Either order or simultaneous handshakes are legal.
- D_WRESP: bready=1; on bvalid set data_done and return to IDLE.
- Latency: with zero-wait AXI, a load or fetch takes 3 cycles of stall; a load plus fetch in the same cycle takes 6.
- Valids, once raised, are not deasserted before their handshake (AXI rule), even if the core's en drops.
- Reset mid-transaction abandons it; the slave is expected to be reset with the bridge.

Decomposition:
- Shared package/defines.vh:
  - FSM state encoding (3-bit localparams).
  - AXI size constants.
  - INST_ID/DATA_ID defaults.
- One natural sub-module, axi_wchan_join: tracks the aw and w handshakes independently and flags both_done.

Test Plan:
- Fetch only, addr 0xBFC00000, slave returns 0x3C1D0001 after arready in cycle 1 and rvalid in cycle 2 -> stallreq_bus high for 3 cycles; inst_sram_rdata=0x3C1D0001; arid=0.
- Simultaneous fetch 0x100 and load 0x8000_0010 -> AR order is data (arid 1) then inst (arid 0); both rdata correct; stall drops only after the second R.
- Store wen=4'b0011, wdata 0xDEADBEEF to 0x20 -> awsize=1, wstrb=0011, wlast=1; stall holds until bvalid.
- Store with wready two cycles before awready -> wvalid drops after its handshake, awvalid stays high; exactly one W beat; single B completes.
- Back-to-back fetches with stall released -> done flags clear the cycle after release; second fetch issues a new AR with a fresh rdata.
- rst asserted while in D_RDATA -> next cycle state IDLE, all valids/readies 0, stallreq_bus reflects en only.
